microsequencer: RTL and testbench

- Control-unit sequencer that consumes the 7-bit entry-state code produced by the instruction encoder.
- Steps through fetch, decode and dispatch, then through the per-instruction execute flow, emitting the control word for each state.
- Sits between the IR/encoder and the datapath (register file, ALU, MAR/MDR, memory).
- Waits on memory-operation-complete (MOC) during memory states.

---
 rtl/microseq_pkg.sv | 68 ++++++
 rtl/microsequencer_microstore.sv | 96 +++++++++
 rtl/microsequencer.sv | 128 ++++++++++++
 tb/tb_microsequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microseq_pkg.sv
// microseq_pkg: shared constants for the microsequencer and its microstore.
// Covers the next-state select encodings, the named microstate codes, the
// control-word width and the bit positions of the datapath control signals.
package microseq_pkg;

  localparam int CTL_W       = 40;
  localparam int MOC_TIMEOUT = 16;

  // Next-state select field of a microword.
  localparam logic [1:0] NS_INC      = 2'b00;
  localparam logic [1:0] NS_FETCH    = 2'b01;
  localparam logic [1:0] NS_DISPATCH = 2'b10;
  localparam logic [1:0] NS_WAITINC  = 2'b11;

  // Fixed states.
  localparam logic [6:0] FETCH_ST   = 7'd1;
  localparam logic [6:0] ILLEGAL_ST = 7'd91;

  localparam logic [6:0] ST_RESET   = 7'd0;
  localparam logic [6:0] ST_FETCH   = FETCH_ST;
  localparam logic [6:0] ST_IRLOAD  = 7'd2;
  localparam logic [6:0] ST_DECODE  = 7'd3;
  localparam logic [6:0] ST_ILLEGAL = ILLEGAL_ST;

  // Encoder entry codes and the follow-on states of their flows.
  localparam logic [6:0] ST_BL          = 7'd40;
  localparam logic [6:0] ST_BL_PC       = 7'd41;
  localparam logic [6:0] ST_BRANCH      = 7'd42;
  localparam logic [6:0] ST_DP_IMM      = 7'd43;
  localparam logic [6:0] ST_DP_SHIFT    = 7'd44;
  localparam logic [6:0] ST_DP_SHIFT_WB = 7'd45;
  localparam logic [6:0] ST_LDR         = 7'd50;
  localparam logic [6:0] ST_LDR_WAIT    = 7'd51;
  localparam logic [6:0] ST_LDR_WB      = 7'd52;
  localparam logic [6:0] ST_STR         = 7'd54;
  localparam logic [6:0] ST_STR_DATA    = 7'd55;
  localparam logic [6:0] ST_STR_WAIT    = 7'd56;
  localparam logic [6:0] ST_STR_DONE    = 7'd57;

  // Control-word bit positions.
  localparam int CTL_PC_OUT     = 0;
  localparam int CTL_PC_LOAD    = 1;
  localparam int CTL_PC_INC     = 2;
  localparam int CTL_MAR_LOAD   = 3;
  localparam int CTL_MDR_LOAD   = 4;
  localparam int CTL_MDR_OUT    = 5;
  localparam int CTL_MEM_READ   = 6;
  localparam int CTL_MEM_WRITE  = 7;
  localparam int CTL_IR_LOAD    = 8;
  localparam int CTL_RF_WRITE   = 9;
  localparam int CTL_RF_OUT_A   = 10;
  localparam int CTL_RF_OUT_B   = 11;
  localparam int CTL_LR_SEL     = 12;
  localparam int CTL_IMM_SEL    = 13;
  localparam int CTL_OFFSET_SEL = 14;
  localparam int CTL_ALU_ADD    = 15;
  localparam int CTL_ALU_OP     = 16;
  localparam int CTL_SHIFT_EN   = 17;

  // One-hot control word with only bit idx set.
  function automatic logic [CTL_W-1:0] cbit(input int idx);
    logic [CTL_W-1:0] w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/microsequencer_microstore.sv
// microstore: combinational lookup from the current microstate to its
// next-state select and control word. States without an entry return to
// fetch with an all-zero control word.
module microstore
  import microseq_pkg::*;
(
  input  logic [6:0]       state,
  output logic [1:0]       nsel,
  output logic [CTL_W-1:0] ctl
);

  // Microstore table.
  always_comb begin
    nsel = NS_FETCH;
    ctl  = '0;
    case (state)
      ST_RESET: begin
        nsel = NS_INC;
      end
      ST_FETCH: begin
        nsel = NS_INC;
        ctl  = cbit(CTL_PC_OUT) | cbit(CTL_MAR_LOAD) | cbit(CTL_MEM_READ);
      end
      ST_IRLOAD: begin
        nsel = NS_WAITINC;
        ctl  = cbit(CTL_MEM_READ) | cbit(CTL_MDR_OUT) | cbit(CTL_IR_LOAD);
      end
      ST_DECODE: begin
        nsel = NS_DISPATCH;
        ctl  = cbit(CTL_PC_INC);
      end
      // BL: LR <- PC, then PC <- PC + offset.
      ST_BL: begin
        nsel = NS_INC;
        ctl  = cbit(CTL_PC_OUT) | cbit(CTL_LR_SEL) | cbit(CTL_RF_WRITE);
      end
      ST_BL_PC: begin
        ctl = cbit(CTL_PC_OUT) | cbit(CTL_OFFSET_SEL) | cbit(CTL_ALU_ADD) | cbit(CTL_PC_LOAD);
      end
      ST_BRANCH: begin
        ctl = cbit(CTL_PC_OUT) | cbit(CTL_OFFSET_SEL) | cbit(CTL_ALU_ADD) | cbit(CTL_PC_LOAD);
      end
      ST_DP_IMM: begin
        ctl = cbit(CTL_RF_OUT_A) | cbit(CTL_IMM_SEL) | cbit(CTL_ALU_OP) | cbit(CTL_RF_WRITE);
      end
      ST_DP_SHIFT: begin
        nsel = NS_INC;
        ctl  = cbit(CTL_RF_OUT_B) | cbit(CTL_SHIFT_EN);
      end
      ST_DP_SHIFT_WB: begin
        ctl = cbit(CTL_RF_OUT_A) | cbit(CTL_ALU_OP) | cbit(CTL_RF_WRITE);
      end
      // LDR: address, memory read with MOC wait, register writeback.
      ST_LDR: begin
        nsel = NS_INC;
        ctl  = cbit(CTL_RF_OUT_A) | cbit(CTL_IMM_SEL) | cbit(CTL_ALU_ADD) | cbit(CTL_MAR_LOAD);
      end
      ST_LDR_WAIT: begin
        nsel = NS_WAITINC;
        ctl  = cbit(CTL_MEM_READ);
      end
      ST_LDR_WB: begin
        ctl = cbit(CTL_MDR_OUT) | cbit(CTL_RF_WRITE);
      end
      // STR: address, data to MDR, memory write with MOC wait, done.
      ST_STR: begin
        nsel = NS_INC;
        ctl  = cbit(CTL_RF_OUT_A) | cbit(CTL_IMM_SEL) | cbit(CTL_ALU_ADD) | cbit(CTL_MAR_LOAD);
      end
      ST_STR_DATA: begin
        nsel = NS_INC;
        ctl  = cbit(CTL_RF_OUT_B) | cbit(CTL_MDR_LOAD);
      end
      ST_STR_WAIT: begin
        nsel = NS_WAITINC;
        ctl  = cbit(CTL_MEM_WRITE);
      end
      ST_STR_DONE: begin
        ctl = '0;
      end
      ST_ILLEGAL: begin
        ctl = '0;
      end
      default: begin
        nsel = NS_FETCH;
        ctl  = '0;
      end
    endcase
  end

  // An INC out of the last state would wrap to reset; the table must not do that.
  always_comb begin
    assert (!(state == 7'h7f && nsel == NS_INC));
  end

endmodule

// File: rtl/microsequencer.sv
// microsequencer: state register and next-state logic of the control unit.
// Walks fetch / IR load / decode, dispatches on the encoder entry code and
// runs the per-instruction flow held in the microstore.
// Optional MOC timeout: define MICROSEQ_MOC_TIMEOUT_EN.
//
// Memory handshake: a WAITINC state holds its control word (the request)
// until moc_IN is sampled high on a rising edge; that same edge advances the
// state, so moc_IN high on the first cycle of the state costs no extra cycle.
module microsequencer
  import microseq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       encoder_IN,
  input  logic             cond_IN,
  input  logic             moc_IN,
  output logic [6:0]       state_OUT,
  output logic [CTL_W-1:0] ctl_OUT,
  output logic             fetch_OUT,
  output logic             illegal_OUT,
  output logic             bus_err_OUT
);

  logic [6:0]       state_q;
  logic [6:0]       state_d;
  logic [1:0]       nsel;
  logic [CTL_W-1:0] ctl;
  logic             illegal_q;
  logic             illegal_set;
  logic             timeout;

  microstore u_store (
    .state (state_q),
    .nsel  (nsel),
    .ctl   (ctl)
  );

`ifdef MICROSEQ_MOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_err_q;

  // The wait gives up on its MOC_TIMEOUT-th cycle unless MOC arrives then.
  assign timeout = (nsel == NS_WAITINC) && !moc_IN &&
                   (wait_cnt == CNT_W'(MOC_TIMEOUT - 1));

  // Count cycles held in a wait state; clear whenever the state is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((nsel == NS_WAITINC) && !moc_IN && !timeout) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky bus-error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else if (timeout) begin
      bus_err_q <= 1'b1;
    end
  end

  assign bus_err_OUT = bus_err_q;
`else
  assign timeout     = 1'b0;
  assign bus_err_OUT = 1'b0;
`endif

  // Next-state selection driven by the microword's nsel field.
  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    case (nsel)
      NS_INC: begin
        state_d = state_q + 7'd1;
      end
      NS_FETCH: begin
        state_d = FETCH_ST;
      end
      NS_DISPATCH: begin
        if (encoder_IN == 7'd0 || !cond_IN) begin
          state_d = FETCH_ST;
        end else if (encoder_IN == ILLEGAL_ST) begin
          state_d     = ILLEGAL_ST;
          illegal_set = 1'b1;
        end else begin
          state_d = encoder_IN;
        end
      end
      NS_WAITINC: begin
        if (moc_IN) begin
          state_d = state_q + 7'd1;
        end else if (timeout) begin
          state_d = FETCH_ST;
        end
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // Sticky undefined-instruction flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (illegal_set) begin
      illegal_q <= 1'b1;
    end
  end

  assign state_OUT   = state_q;
  assign ctl_OUT     = ctl;
  assign fetch_OUT   = (state_q == FETCH_ST);
  assign illegal_OUT = illegal_q;

endmodule

// File: tb/tb_microsequencer.sv
// tb_microsequencer: directed and randomized bench for microsequencer with a
// flow-level reference model and an expected-value queue.
`timescale 1ns/1ps
module tb_microsequencer;
  import microseq_pkg::*;

`ifdef MICROSEQ_MOC_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif
  localparam int TB_TIMEOUT = 16;
  localparam int W = 10;

  // Kinds of microstate, as seen by the model.
  localparam int K_DEF  = 0;  // no table entry: back to fetch, ctl zero
  localparam int K_INC  = 1;
  localparam int K_WAIT = 2;
  localparam int K_DISP = 3;
  localparam int K_FIN  = 4;  // last state of a flow: back to fetch

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       encoder = 7'd0;
  logic             cond = 1'b1;
  logic             moc = 1'b0;
  logic [6:0]       state_out;
  logic [CTL_W-1:0] ctl_out;
  logic             fetch_out;
  logic             illegal_out;
  logic             bus_err_out;

  always #5 clk = ~clk;

  microsequencer dut (
    .clk         (clk),
    .reset       (reset),
    .encoder_IN  (encoder),
    .cond_IN     (cond),
    .moc_IN      (moc),
    .state_OUT   (state_out),
    .ctl_OUT     (ctl_out),
    .fetch_OUT   (fetch_out),
    .illegal_OUT (illegal_out),
    .bus_err_OUT (bus_err_out)
  );

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int kind[128];

  // A flow of len states starting at entry; wait_pos is the offset of its
  // MOC wait state (-1 for none); the last state returns to fetch.
  task automatic add_flow(input int entry, input int len, input int wait_pos);
    for (int k = 0; k < len; k++) begin
      if (k == len - 1) kind[entry + k] = K_FIN;
      else if (k == wait_pos) kind[entry + k] = K_WAIT;
      else kind[entry + k] = K_INC;
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) kind[k] = K_DEF;
    kind[0] = K_INC;
    kind[1] = K_INC;
    kind[2] = K_WAIT;
    kind[3] = K_DISP;
    add_flow(40, 2, -1);  // BL
    add_flow(42, 1, -1);  // branch
    add_flow(43, 1, -1);  // data processing, immediate
    add_flow(44, 2, -1);  // data processing, shifted
    add_flow(50, 3, 1);   // LDR
    add_flow(54, 4, 2);   // STR
    kind[91] = K_FIN;     // illegal
  end

  logic [6:0] m_state = 7'd0;
  bit         m_ill = 1'b0;
  bit         m_err = 1'b0;
  int         m_wait = 0;
  logic [W-1:0] exp_q[$];

  // Model: advance one cycle from the inputs present at this edge.
  always @(posedge clk) begin
    logic [6:0] n;
    if (reset) begin
      m_state = 7'd0;
      m_ill   = 1'b0;
      m_err   = 1'b0;
      m_wait  = 0;
    end else begin
      n = m_state;
      case (kind[m_state])
        K_INC: n = m_state + 7'd1;
        K_WAIT: begin
          if (moc) begin
            n = m_state + 7'd1;
            m_wait = 0;
          end else if (TO_ON && m_wait == TB_TIMEOUT - 1) begin
            n = 7'd1;
            m_err = 1'b1;
            m_wait = 0;
          end else begin
            m_wait++;
          end
        end
        K_DISP: begin
          if (encoder == 7'd0 || !cond) n = 7'd1;
          else begin
            n = encoder;
            if (encoder == 7'd91) m_ill = 1'b1;
          end
        end
        default: n = 7'd1;
      endcase
      if (kind[m_state] != K_WAIT) m_wait = 0;
      m_state = n;
    end
    exp_q.push_back({m_state, m_state == 7'd1, m_ill, m_err});
  end

  // Compare: every cycle, DUT outputs against the model's expectation.
  always @(posedge clk) begin
    logic [W-1:0] e;
    logic [6:0]   es;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e  = exp_q.pop_front();
      es = e[9:3];
      if (check_en) begin
        check("state", state_out, es);
        check("fetch", fetch_out, e[2]);
        check("illegal", illegal_out, e[1]);
        check("bus_err", bus_err_out, e[0]);
        if (es == 7'd0 || kind[es] == K_DEF) check("ctl_zero", ctl_out, 0);
        if (es == 7'd1) check("ctl_fetch_read", {ctl_out[CTL_MAR_LOAD], ctl_out[CTL_MEM_READ]}, 2'b11);
        if (es == 7'd2) check("ctl_irload", ctl_out[CTL_IR_LOAD], 1'b1);
        if (es == 7'd3) check("ctl_pc_inc", ctl_out[CTL_PC_INC], 1'b1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic r, input logic [6:0] e, input logic c, input logic m);
    @(negedge clk);
    reset = r; encoder = e; cond = c; moc = m;
    @(posedge clk);
    #2;
  endtask

  // From state 1: through IR load (MOC ready) to decode.
  task automatic to_decode(input logic [6:0] e1, input logic [6:0] e2);
    step(1'b0, e1, 1'b1, 1'b1);
    step(1'b0, e2, 1'b1, 1'b1);
  endtask

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [6:0] e;
    logic r, c, m;
    int pick;

    // Reset state.
    step(1'b1, 7'd0, 1'b1, 1'b0);
    check_en = 1'b1;
    check("lit_reset_state", state_out, 7'd0);
    check("lit_reset_ctl", ctl_out, 0);
    check("lit_reset_flags", {fetch_out, illegal_out, bus_err_out}, 3'b000);

    // Fetch wait: five cycles in state 2 with MOC low, then advance.
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_fetch", {state_out, fetch_out}, {7'd1, 1'b1});
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_irload_enter", state_out, 7'd2);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 7'd0, 1'b1, 1'b0);
      check("lit_irload_hold", state_out, 7'd2);
    end
    step(1'b0, 7'd0, 1'b1, 1'b1);
    check("lit_decode", state_out, 7'd3);

    // Dispatch to branch, then back to fetch.
    step(1'b0, 7'd42, 1'b1, 1'b0);
    check("lit_branch", state_out, 7'd42);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_branch_done", {state_out, fetch_out}, {7'd1, 1'b1});

    // Condition false: skip straight to fetch.
    to_decode(7'd0, 7'd0);
    step(1'b0, 7'd42, 1'b0, 1'b0);
    check("lit_cond_skip", state_out, 7'd1);

    // NOP.
    to_decode(7'd0, 7'd0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_nop", {state_out, illegal_out}, {7'd1, 1'b0});

    // Illegal instruction; flag is sticky.
    to_decode(7'd0, 7'd0);
    step(1'b0, 7'd91, 1'b1, 1'b0);
    check("lit_illegal", {state_out, illegal_out}, {7'd91, 1'b1});
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_illegal_sticky", {state_out, illegal_out}, {7'd1, 1'b1});

    // Encoder toggling before decode is ignored.
    to_decode(7'd40, 7'd43);
    check("lit_sample_decode", state_out, 7'd3);
    step(1'b0, 7'd43, 1'b1, 1'b0);
    check("lit_sample_dp_imm", state_out, 7'd43);
    step(1'b0, 7'd40, 1'b1, 1'b0);
    check("lit_sample_done", state_out, 7'd1);

    // Reset mid-flow in state 44.
    to_decode(7'd0, 7'd0);
    step(1'b0, 7'd44, 1'b1, 1'b0);
    check("lit_dp_shift", state_out, 7'd44);
    step(1'b1, 7'd0, 1'b1, 1'b0);
    check("lit_midflow_reset", {state_out, ctl_out}, {7'd0, {CTL_W{1'b0}}});
    check("lit_midflow_flags", {illegal_out, bus_err_out}, 2'b00);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_restart_fetch", state_out, 7'd1);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_restart_hold", state_out, 7'd2);
    step(1'b0, 7'd0, 1'b1, 1'b1);
    check("lit_restart_decode", state_out, 7'd3);

    // Long MOC wait.
    step(1'b0, 7'd0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_wait15", state_out, 7'd2);
    step(1'b0, 7'd0, 1'b1, 1'b0);
`ifdef MICROSEQ_MOC_TIMEOUT_EN
    check("lit_timeout", {state_out, bus_err_out}, {7'd1, 1'b1});
    step(1'b1, 7'd0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b0);
    for (int k = 0; k < 15; k++) step(1'b0, 7'd0, 1'b1, 1'b0);
    step(1'b0, 7'd0, 1'b1, 1'b1);
    check("lit_moc_wins", {state_out, bus_err_out}, {7'd3, 1'b0});
`else
    check("lit_no_timeout", {state_out, bus_err_out}, {7'd2, 1'b0});
    for (int k = 0; k < 8; k++) step(1'b0, 7'd0, 1'b1, 1'b0);
    check("lit_wait_unbounded", {state_out, bus_err_out}, {7'd2, 1'b0});
`endif

    // Randomized run, checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      pick = $urandom_range(0, 9);
      case (pick)
        0: e = 7'd0;
        1: e = 7'd40;
        2: e = 7'd42;
        3: e = 7'd43;
        4: e = 7'd44;
        5: e = 7'd50;
        6: e = 7'd54;
        7: e = 7'd91;
        default: e = 7'($urandom_range(0, 127));
      endcase
      c = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 2) == 0);
      if ((i % 400) < 30) m = 1'b0;
      step(r, e, c, m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
